lsu_axil_master: RTL

- AXI-lite initiator that turns the LSU's single-outstanding load/store request into AXI-lite read or write channel transactions toward the main-memory responder.
- Returns load data with size and sign extension applied, and reports bus or alignment errors.
- Sits between the LSU stage and the memory-side AXI-lite responder. Exactly one transaction is in flight at a time.

---
 rtl/lsu_axil_master_pkg.sv | 38 +++
 rtl/lsu_axil_master_if.sv | 59 +++++
 rtl/lsu_load_align.sv | 32 +++
 rtl/lsu_axil_master.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/lsu_axil_master_pkg.sv
// Shared LSU/AXI-lite definitions: size codes, xRESP codes, FSM states and the request legality check.
// The OKAY macro is shared with the memory responder, so it is defined only if nothing else has defined it.
`ifndef AXI_RESP_OKAY
`define AXI_RESP_OKAY 2'b00
`endif

package lsu_axil_master_pkg;

    typedef enum logic [1:0] {
        SZ_ILLEGAL = 2'b00,
        SZ_BYTE    = 2'b01,
        SZ_HALF    = 2'b10,
        SZ_WORD    = 2'b11
    } size_e;

    localparam logic [1:0] RESP_OKAY_C   = `AXI_RESP_OKAY;
    localparam logic [1:0] RESP_SLVERR_C = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_ADDR,
        ST_RD_DATA,
        ST_WR_REQ,
        ST_WR_RESP,
        ST_RESP
    } state_e;

    // Natural alignment only; size 00 is never legal.
    function automatic logic req_legal(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            SZ_BYTE: return 1'b1;
            SZ_HALF: return ~addr_lo[0];
            SZ_WORD: return (addr_lo == 2'b00);
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_axil_master_if.sv
// LSU request/response channel plus the AXI-lite read and write channels of the memory port.
// master = the initiator block, slave = the LSU and memory responder that surround it.
interface lsu_axil_master_if #(parameter int ADDR_W = 32);

    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [1:0]        req_size;
    logic              req_signed;
    logic [31:0]       req_wdata;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;

    logic [ADDR_W-1:0] araddr;
    logic              arvalid;
    logic              arready;
    logic [31:0]       rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;

    logic [ADDR_W-1:0] awaddr;
    logic              awvalid;
    logic              awready;
    logic [31:0]       wdata;
    logic [1:0]        wstrb;
    logic              wvalid;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;

    modport master (
        input  req_valid, req_we, req_addr, req_size, req_signed, req_wdata,
        output req_ready,
        output rsp_valid, rsp_rdata, rsp_err,
        input  rsp_ready,
        output araddr, arvalid, rready,
        input  arready, rdata, rresp, rvalid,
        output awaddr, awvalid, wdata, wstrb, wvalid, bready,
        input  awready, wready, bresp, bvalid
    );

    modport slave (
        output req_valid, req_we, req_addr, req_size, req_signed, req_wdata,
        input  req_ready,
        input  rsp_valid, rsp_rdata, rsp_err,
        output rsp_ready,
        input  araddr, arvalid, rready,
        output arready, rdata, rresp, rvalid,
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready,
        output awready, wready, bresp, bvalid
    );

endinterface

// File: rtl/lsu_load_align.sv
// Picks the addressed byte/half/word out of a read beat and zero- or sign-extends it to 32 bits.
// Purely combinational; no handshake.
module lsu_load_align
    import lsu_axil_master_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (addr_lo)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

        case (size)
            SZ_BYTE: data = {{24{sign_ext & byte_sel[7]}}, byte_sel};
            SZ_HALF: data = {{16{sign_ext & half_sel[15]}}, half_sel};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/lsu_axil_master.sv
// Single-outstanding AXI-lite initiator for LSU loads/stores; zero-wait latency is 3 cycles, pre-check errors 1 cycle.
// Accepts a request only in IDLE and holds the response until rsp_ready; all valids are registered.
module lsu_axil_master
    import lsu_axil_master_pkg::*;
#(
    parameter int         ADDR_W    = 32,
    parameter logic [1:0] RESP_OKAY = RESP_OKAY_C
) (
    input  logic                    clk,
    input  logic                    rst,
    lsu_axil_master_if.master       bus
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        size_q, size_d;
    logic              signed_q, signed_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              arvalid_q, arvalid_d;
    logic              rready_q, rready_d;
    logic              awvalid_q, awvalid_d;
    logic              wvalid_q, wvalid_d;
    logic              bready_q, bready_d;
    logic              aw_done_q, aw_done_d;
    logic              w_done_q, w_done_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_err_q, rsp_err_d;
    logic [31:0]       rsp_rdata_q, rsp_rdata_d;

    logic [31:0]       load_val;
    logic              aw_now;
    logic              w_now;
    logic              bus_err;

    lsu_load_align u_load_align (
        .rdata    (bus.rdata),
        .addr_lo  (addr_q[1:0]),
        .size     (size_q),
        .sign_ext (signed_q),
        .data     (load_val)
    );

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        size_d      = size_q;
        signed_d    = signed_q;
        wdata_d     = wdata_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        bready_d    = bready_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        rsp_valid_d = rsp_valid_q;
        rsp_err_d   = rsp_err_q;
        rsp_rdata_d = rsp_rdata_q;
        aw_now      = aw_done_q | (awvalid_q & bus.awready);
        w_now       = w_done_q | (wvalid_q & bus.wready);
        bus_err     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    addr_d   = bus.req_addr;
                    size_d   = bus.req_size;
                    signed_d = bus.req_signed;
                    wdata_d  = bus.req_wdata;
                    if (!req_legal(bus.req_size, bus.req_addr[1:0])) begin
                        // Rejected locally: no AXI channel sees this request.
                        state_d     = ST_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = 32'd0;
                    end else if (bus.req_we) begin
                        state_d   = ST_WR_REQ;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        aw_done_d = 1'b0;
                        w_done_d  = 1'b0;
                    end else begin
                        state_d   = ST_RD_ADDR;
                        arvalid_d = 1'b1;
                    end
                end
            end
            ST_RD_ADDR: begin
                if (bus.arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = ST_RD_DATA;
                end
            end
            ST_RD_DATA: begin
                if (bus.rvalid) begin
                    bus_err     = (bus.rresp != RESP_OKAY);
                    rready_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = bus_err;
                    rsp_rdata_d = bus_err ? 32'd0 : load_val;
                    state_d     = ST_RESP;
                end
            end
            ST_WR_REQ: begin
                // AW and W complete independently; each valid drops right after its own handshake.
                if (awvalid_q && bus.awready) awvalid_d = 1'b0;
                if (wvalid_q && bus.wready)   wvalid_d  = 1'b0;
                aw_done_d = aw_now;
                w_done_d  = w_now;
                if (aw_now && w_now) begin
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    bready_d  = 1'b1;
                    state_d   = ST_WR_RESP;
                end
            end
            ST_WR_RESP: begin
                if (bus.bvalid) begin
                    bready_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = (bus.bresp != RESP_OKAY);
                    rsp_rdata_d = 32'd0;
                    state_d     = ST_RESP;
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = 32'd0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            size_q      <= 2'b00;
            signed_q    <= 1'b0;
            wdata_q     <= 32'd0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            size_q      <= size_d;
            signed_q    <= signed_d;
            wdata_q     <= wdata_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign bus.req_ready = (state_q == ST_IDLE);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.araddr    = {addr_q[ADDR_W-1:2], 2'b00};
    assign bus.arvalid   = arvalid_q;
    assign bus.rready    = rready_q;
    assign bus.awaddr    = addr_q;
    assign bus.awvalid   = awvalid_q;
    assign bus.wdata     = wdata_q;
    assign bus.wstrb     = size_q;
    assign bus.wvalid    = wvalid_q;
    assign bus.bready    = bready_q;

endmodule
